// File: rtl/traffic_pkg.sv
// Shared state encoding, default phase lengths and lamp decode for traffic_light_ctrl.
// TRAFFIC_ALL_RED_EN adds the ALL_RED clearance state; its encoding and length live here unconditionally.
package traffic_pkg;

    localparam int unsigned NS_GREEN_CYCLES_DEF = 32'd32;
    localparam int unsigned EW_GREEN_CYCLES_DEF = 32'd16;
    localparam int unsigned YELLOW_CYCLES_DEF   = 32'd4;
    localparam int unsigned ALL_RED_CYCLES      = 32'd2;

    typedef enum logic [2:0] {
        ST_NS_GREEN  = 3'd0,
        ST_NS_YELLOW = 3'd1,
        ST_EW_GREEN  = 3'd2,
        ST_EW_YELLOW = 3'd3,
        ST_ALL_RED   = 3'd4
    } state_e;

    localparam logic [2:0] S_NS_GREEN  = ST_NS_GREEN;
    localparam logic [2:0] S_NS_YELLOW = ST_NS_YELLOW;
    localparam logic [2:0] S_EW_GREEN  = ST_EW_GREEN;
    localparam logic [2:0] S_EW_YELLOW = ST_EW_YELLOW;
    localparam logic [2:0] S_ALL_RED   = ST_ALL_RED;

    // Lamp vector order: {NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green}
    localparam logic [5:0] LAMPS_NS_GREEN  = 6'b001_100;
    localparam logic [5:0] LAMPS_NS_YELLOW = 6'b010_100;
    localparam logic [5:0] LAMPS_EW_GREEN  = 6'b100_001;
    localparam logic [5:0] LAMPS_EW_YELLOW = 6'b100_010;
    localparam logic [5:0] LAMPS_ALL_RED   = 6'b100_100;

    // Unknown encodings fall back to all-red so a corrupted state never lights a conflicting go.
    function automatic logic [5:0] lamp_decode(input logic [2:0] state);
        logic [5:0] lamps;
        case (state)
            S_NS_GREEN:  lamps = LAMPS_NS_GREEN;
            S_NS_YELLOW: lamps = LAMPS_NS_YELLOW;
            S_EW_GREEN:  lamps = LAMPS_EW_GREEN;
            S_EW_YELLOW: lamps = LAMPS_EW_YELLOW;
            S_ALL_RED:   lamps = LAMPS_ALL_RED;
            default:     lamps = LAMPS_ALL_RED;
        endcase
        return lamps;
    endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Phase timer: clears to zero, counts up while enabled and saturates at MAX_COUNT,
// with a terminal-count flag that stays high while saturated.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32'd4,
    parameter logic [WIDTH-1:0] MAX_COUNT = '1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins, otherwise increment until saturated.
    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_en && (count_q != MAX_COUNT)) begin
            count_d = count_q + ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
    assign o_tc    = (count_q == MAX_COUNT);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-way intersection controller: synchronized detectors, three phase timers and a Moore FSM.
// Define TRAFFIC_ALL_RED_EN to insert a two-cycle all-red clearance after every yellow.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned NS_GREEN_CYCLES = NS_GREEN_CYCLES_DEF,
    parameter int unsigned EW_GREEN_CYCLES = EW_GREEN_CYCLES_DEF,
    parameter int unsigned YELLOW_CYCLES   = YELLOW_CYCLES_DEF,
    localparam int unsigned NS_W = $clog2(NS_GREEN_CYCLES),
    localparam int unsigned EW_W = $clog2(EW_GREEN_CYCLES),
    localparam int unsigned Y_W  = $clog2(YELLOW_CYCLES)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            NS_vehicle_detect,
    input  logic            EW_vehicle_detect,
    output logic            NS_red,
    output logic            NS_yellow,
    output logic            NS_green,
    output logic            EW_red,
    output logic            EW_yellow,
    output logic            EW_green,
    output logic [NS_W-1:0] o_ns_count,
    output logic [EW_W-1:0] o_ew_count,
    output logic [Y_W-1:0]  o_yellow_count
);

    logic [1:0] ns_sync_q;
    logic [1:0] ns_sync_d;
    logic [1:0] ew_sync_q;
    logic [1:0] ew_sync_d;
    logic       ns_req_s;
    logic       ew_req_s;

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [5:0] lamps_q;
    logic [5:0] lamps_d;

    logic       ns_tc_s;
    logic       ew_tc_s;
    logic       y_tc_s;
    logic       ns_run_s;
    logic       ew_run_s;
    logic       y_run_s;

`ifdef TRAFFIC_ALL_RED_EN
    // Set when the clearance in progress followed the NS yellow, so EW is served next.
    logic       last_ns_q;
    logic       last_ns_d;
`endif

    // Shift the raw detector levels into the two-stage synchronizers.
    always_comb begin
        ns_sync_d = {ns_sync_q[0], NS_vehicle_detect};
        ew_sync_d = {ew_sync_q[0], EW_vehicle_detect};
    end

    // Synchronizer flops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ns_sync_q <= 2'b00;
            ew_sync_q <= 2'b00;
        end else begin
            ns_sync_q <= ns_sync_d;
            ew_sync_q <= ew_sync_d;
        end
    end

    assign ns_req_s = ns_sync_q[1];
    assign ew_req_s = ew_sync_q[1];

    // Next-state logic; demand is only looked at when the green timer has expired.
    always_comb begin
        state_d = state_q;
`ifdef TRAFFIC_ALL_RED_EN
        last_ns_d = last_ns_q;
`endif
        case (state_q)
            S_NS_GREEN: begin
                if (ns_tc_s && ew_req_s) begin
                    state_d = S_NS_YELLOW;
                end else begin
                    state_d = state_q;
                end
            end
            S_NS_YELLOW: begin
                if (y_tc_s) begin
`ifdef TRAFFIC_ALL_RED_EN
                    state_d   = S_ALL_RED;
                    last_ns_d = 1'b1;
`else
                    state_d   = S_EW_GREEN;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            S_EW_GREEN: begin
                if (ew_tc_s && (ns_req_s || !ew_req_s)) begin
                    state_d = S_EW_YELLOW;
                end else begin
                    state_d = state_q;
                end
            end
            S_EW_YELLOW: begin
                if (y_tc_s) begin
`ifdef TRAFFIC_ALL_RED_EN
                    state_d   = S_ALL_RED;
                    last_ns_d = 1'b0;
`else
                    state_d   = S_NS_GREEN;
`endif
                end else begin
                    state_d = state_q;
                end
            end
`ifdef TRAFFIC_ALL_RED_EN
            S_ALL_RED: begin
                if (o_yellow_count == Y_W'(ALL_RED_CYCLES - 32'd1)) begin
                    if (last_ns_q) begin
                        state_d = S_EW_GREEN;
                    end else begin
                        state_d = S_NS_GREEN;
                    end
                end else begin
                    state_d = state_q;
                end
            end
`endif
            default: state_d = S_NS_GREEN;
        endcase
    end

    // A timer only keeps counting while its phase continues into the next cycle,
    // so every phase entry shows count 0.
    always_comb begin
        ns_run_s = (state_q == S_NS_GREEN) && (state_d == S_NS_GREEN);
        ew_run_s = (state_q == S_EW_GREEN) && (state_d == S_EW_GREEN);
        y_run_s  = (state_q == state_d) &&
                   ((state_q == S_NS_YELLOW) || (state_q == S_EW_YELLOW) ||
                    (state_q == S_ALL_RED));
    end

    // Lamps are registered from the next state, so they always match the state register.
    always_comb begin
        lamps_d = lamp_decode(state_d);
    end

    // State and lamp registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_NS_GREEN;
            lamps_q <= LAMPS_NS_GREEN;
        end else begin
            state_q <= state_d;
            lamps_q <= lamps_d;
        end
    end

`ifdef TRAFFIC_ALL_RED_EN
    // Direction-served-last register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_ns_q <= 1'b0;
        end else begin
            last_ns_q <= last_ns_d;
        end
    end
`endif

    traffic_phase_timer #(
        .WIDTH     (NS_W),
        .MAX_COUNT (NS_W'(NS_GREEN_CYCLES - 32'd1))
    ) u_ns_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (!ns_run_s),
        .i_en    (ns_run_s),
        .o_count (o_ns_count),
        .o_tc    (ns_tc_s)
    );

    traffic_phase_timer #(
        .WIDTH     (EW_W),
        .MAX_COUNT (EW_W'(EW_GREEN_CYCLES - 32'd1))
    ) u_ew_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (!ew_run_s),
        .i_en    (ew_run_s),
        .o_count (o_ew_count),
        .o_tc    (ew_tc_s)
    );

    traffic_phase_timer #(
        .WIDTH     (Y_W),
        .MAX_COUNT (Y_W'(YELLOW_CYCLES - 32'd1))
    ) u_yellow_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (!y_run_s),
        .i_en    (y_run_s),
        .o_count (o_yellow_count),
        .o_tc    (y_tc_s)
    );

    assign {NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green} = lamps_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: expected lamps/counts are pushed to a scoreboard
// per sample point and popped against the DUT; honours TRAFFIC_ALL_RED_EN.
module tb_traffic_light_ctrl;

    localparam logic [5:0] L_NSG = 6'b001100;
    localparam logic [5:0] L_NSY = 6'b010100;
    localparam logic [5:0] L_EWG = 6'b100001;
    localparam logic [5:0] L_EWY = 6'b100010;
    localparam logic [5:0] L_AR  = 6'b100100;
`ifdef TRAFFIC_ALL_RED_EN
    localparam int AR = 2;
`else
    localparam int AR = 0;
`endif
    // Sample index of the first EW green after reset with EW demand held.
    localparam int E = 36 + AR;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ns_det = 1'b0;
    logic       ew_det = 1'b0;
    logic       NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green;
    logic [4:0] ns_cnt;
    logic [3:0] ew_cnt;
    logic [1:0] y_cnt;

    always #5 clk = ~clk;

    traffic_light_ctrl dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .NS_vehicle_detect (ns_det),
        .EW_vehicle_detect (ew_det),
        .NS_red            (NS_red),
        .NS_yellow         (NS_yellow),
        .NS_green          (NS_green),
        .EW_red            (EW_red),
        .EW_yellow         (EW_yellow),
        .EW_green          (EW_green),
        .o_ns_count        (ns_cnt),
        .o_ew_count        (ew_cnt),
        .o_yellow_count    (y_cnt)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_underflow observed=0x%0h expected=an entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) passed++;
            else $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
        end
    endtask

    task automatic expect_state(input string tag, input logic [5:0] l,
                                input int nsc, input int ewc, input int yc);
        push({tag, "_lamps"}, 32'(l));
        push({tag, "_ns"}, 32'(nsc));
        push({tag, "_ew"}, 32'(ewc));
        push({tag, "_y"}, 32'(yc));
    endtask

    task automatic check_state();
        pop_cmp(32'({NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green}));
        pop_cmp(32'(ns_cnt));
        pop_cmp(32'(ew_cnt));
        pop_cmp(32'(y_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Leaves the bench 2 time units after a rising edge with reset just released (sample 0).
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // No EW demand: NS green held well past 100 cycles, then EW raised to measure latency.
        ns_det = 1'b1;
        ew_det = 1'b0;
        do_reset();
        for (int k = 0; k <= 126; k++) begin
            if (k < 123) expect_state($sformatf("hold%0d", k), L_NSG, (k > 31) ? 31 : k, 0, 0);
            else         expect_state($sformatf("hold%0d", k), L_NSY, 0, 0, k - 123);
            check_state();
            if (k == 120) ew_det = 1'b1;
            tick();
        end

        // A short EW pulse long before NS green expiry is not remembered.
        ns_det = 1'b0;
        ew_det = 1'b0;
        do_reset();
        for (int k = 0; k <= 59; k++) begin
            expect_state($sformatf("drop%0d", k), L_NSG, (k > 31) ? 31 : k, 0, 0);
            check_state();
            if (k == 5) ew_det = 1'b1;
            if (k == 8) ew_det = 1'b0;
            tick();
        end

        // EW demand only: full NS green, yellow, then EW green held saturated.
        ns_det = 1'b0;
        ew_det = 1'b1;
        do_reset();
        for (int k = 0; k <= E + 30; k++) begin
            if (k < 32)      expect_state($sformatf("ew%0d", k), L_NSG, k, 0, 0);
            else if (k < 36) expect_state($sformatf("ew%0d", k), L_NSY, 0, 0, k - 32);
            else if (k < E)  expect_state($sformatf("ew%0d", k), L_AR, 0, 0, k - 36);
            else             expect_state($sformatf("ew%0d", k), L_EWG, 0,
                                          (k - E > 15) ? 15 : k - E, 0);
            check_state();
            tick();
        end

        // Asynchronous reset in the middle of EW green clears everything at once.
        #1;
        rst_n = 1'b0;
        #1;
        expect_state("async_rst", L_NSG, 0, 0, 0);
        check_state();

        // NS raised at EW count 5: EW green runs to 15, yellow, then NS green.
        ns_det = 1'b0;
        ew_det = 1'b1;
        do_reset();
        for (int k = 0; k <= E + 30; k++) begin
            if (k < 32)               expect_state($sformatf("nsr%0d", k), L_NSG, k, 0, 0);
            else if (k < 36)          expect_state($sformatf("nsr%0d", k), L_NSY, 0, 0, k - 32);
            else if (k < E)           expect_state($sformatf("nsr%0d", k), L_AR, 0, 0, k - 36);
            else if (k < E + 16)      expect_state($sformatf("nsr%0d", k), L_EWG, 0, k - E, 0);
            else if (k < E + 20)      expect_state($sformatf("nsr%0d", k), L_EWY, 0, 0, k - E - 16);
            else if (k < E + 20 + AR) expect_state($sformatf("nsr%0d", k), L_AR, 0, 0, k - E - 20);
            else                      expect_state($sformatf("nsr%0d", k), L_NSG, k - E - 20 - AR, 0, 0);
            check_state();
            if (k == E + 5) ns_det = 1'b1;
            tick();
        end

        // Random detector activity: lamp safety invariants every cycle.
        ns_det = 1'b0;
        ew_det = 1'b0;
        do_reset();
        for (int k = 0; k < 1000; k++) begin
            push("ns_onehot", 32'd1);
            pop_cmp(32'($onehot({NS_red, NS_yellow, NS_green})));
            push("ew_onehot", 32'd1);
            pop_cmp(32'($onehot({EW_red, EW_yellow, EW_green})));
            push("one_red_min", 32'd1);
            pop_cmp(32'(NS_red | EW_red));
            if ($urandom_range(0, 15) == 0) ns_det = ~ns_det;
            if ($urandom_range(0, 15) == 0) ew_det = ~ew_det;
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
